// File: rtl/alu_muldiv_seq.sv
// Sequential shift-add multiplier / restoring divider, one bit per clock.
// Optional signed support is compiled in with `define ALU_MULDIV_SIGNED_EN.
module alu_muldiv_seq #(
   parameter int WIDTH = 16
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             en_i,
   input  logic             start_i,
   input  logic             op_div_i,
   input  logic             op_signed_i,
   input  logic [WIDTH-1:0] opa_i,
   input  logic [WIDTH-1:0] opb_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] result_lo_o,
   output logic [WIDTH-1:0] result_hi_o,
   output logic             div_zero_o
);
   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
   logic [WIDTH-1:0] res_lo_q, res_lo_d, res_hi_q, res_hi_d;
   logic             div_q, div_d, dz_q, dz_d;
   logic             negp_q, negp_d, negr_q, negr_d;

   logic [WIDTH-1:0] a_mag, b_mag, step_hi, step_lo, fix_hi, fix_lo;
   logic [WIDTH:0]   mul_sum, rem_sh, rem_sub;
   logic             qbit, a_neg, b_neg;

`ifdef ALU_MULDIV_SIGNED_EN
   logic [2*WIDTH-1:0] prod;
   assign a_neg = op_signed_i & opa_i[WIDTH-1];
   assign b_neg = op_signed_i & opb_i[WIDTH-1];
`else
   logic unused_sgn;
   assign unused_sgn = op_signed_i;
   assign a_neg = 1'b0;
   assign b_neg = 1'b0;
`endif
   assign a_mag = a_neg ? (~opa_i + 1'b1) : opa_i;
   assign b_mag = b_neg ? (~opb_i + 1'b1) : opb_i;

   // hi is the running partial product (MUL) or partial remainder (DIV);
   // lo holds the multiplier / dividend being consumed and collects product / quotient bits.
   always_comb begin
      mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
      rem_sh  = {hi_q, lo_q[WIDTH-1]};
      rem_sub = rem_sh - {1'b0, opnd_q};
      qbit    = ~rem_sub[WIDTH];
      if (div_q) begin
         step_hi = qbit ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
         step_lo = {lo_q[WIDTH-2:0], qbit};
      end else begin
         step_hi = mul_sum[WIDTH:1];
         step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
      end
   end

   always_comb begin
      fix_hi = step_hi;
      fix_lo = step_lo;
`ifdef ALU_MULDIV_SIGNED_EN
      prod = {step_hi, step_lo};
      if (div_q) begin
         if (negp_q) fix_lo = ~step_lo + 1'b1;
         if (negr_q) fix_hi = ~step_hi + 1'b1;
      end else if (negp_q) begin
         prod = ~prod + 1'b1;
         {fix_hi, fix_lo} = prod;
      end
`endif
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      opnd_d   = opnd_q;
      div_d    = div_q;
      dz_d     = dz_q;
      negp_d   = negp_q;
      negr_d   = negr_q;
      res_lo_d = res_lo_q;
      res_hi_d = res_hi_q;
      if (!en_i) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: if (start_i) begin
               if (op_div_i && opb_i == '0) begin
                  state_d  = DONE;
                  div_d    = 1'b1;
                  dz_d     = 1'b1;
                  res_lo_d = '1;
                  res_hi_d = opa_i;
               end else begin
                  state_d = CALC;
                  cnt_d   = CW'(WIDTH);
                  div_d   = op_div_i;
                  dz_d    = 1'b0;
                  hi_d    = '0;
                  lo_d    = op_div_i ? a_mag : b_mag;
                  opnd_d  = op_div_i ? b_mag : a_mag;
                  negp_d  = a_neg ^ b_neg;
                  negr_d  = a_neg;
               end
            end
            CALC: begin
               hi_d  = step_hi;
               lo_d  = step_lo;
               cnt_d = cnt_q - 1'b1;
               if (cnt_q == CW'(1)) begin
                  state_d  = DONE;
                  res_lo_d = fix_lo;
                  res_hi_d = fix_hi;
               end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         opnd_q   <= '0;
         div_q    <= 1'b0;
         dz_q     <= 1'b0;
         negp_q   <= 1'b0;
         negr_q   <= 1'b0;
         res_lo_q <= '0;
         res_hi_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         opnd_q   <= opnd_d;
         div_q    <= div_d;
         dz_q     <= dz_d;
         negp_q   <= negp_d;
         negr_q   <= negr_d;
         res_lo_q <= res_lo_d;
         res_hi_q <= res_hi_d;
      end
   end

   assign busy_o      = (state_q != IDLE);
   assign done_o      = (state_q == DONE);
   assign result_lo_o = res_lo_q;
   assign result_hi_o = res_hi_q;
   assign div_zero_o  = dz_q;
endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed scoreboard bench for alu_muldiv_seq; expectations from a behavioural arithmetic model.
module tb_alu_muldiv_seq;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0, en = 1'b1, start = 1'b0, op_div = 1'b0, op_signed = 1'b0;
   logic [15:0] opa = '0, opb = '0;
   logic        busy, done, div_zero;
   logic [15:0] result_lo, result_hi;

   typedef struct { logic [15:0] lo; logic [15:0] hi; logic dz; } exp_t;
   exp_t sb[$];
   int checks = 0, failures = 0;

   alu_muldiv_seq #(.WIDTH(16)) dut (
      .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .start_i(start), .op_div_i(op_div),
      .op_signed_i(op_signed), .opa_i(opa), .opb_i(opb), .busy_o(busy), .done_o(done),
      .result_lo_o(result_lo), .result_hi_o(result_hi), .div_zero_o(div_zero));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input bit dv, input bit sg, input logic [15:0] a, input logic [15:0] b);
      exp_t   e;
      bit     s;
      longint p;
      int     sa, sbv;
`ifdef ALU_MULDIV_SIGNED_EN
      s = sg;
`else
      s = 1'b0;
`endif
      e.dz = 1'b0;
      if (dv && b == 16'h0) begin
         e.lo = 16'hFFFF; e.hi = a; e.dz = 1'b1;
      end else if (!dv) begin
         if (s) p = longint'($signed(a)) * longint'($signed(b));
         else   p = longint'(a) * longint'(b);
         e.lo = p[15:0]; e.hi = p[31:16];
      end else begin
         if (s) begin sa = $signed(a); sbv = $signed(b); end
         else   begin sa = int'(a);    sbv = int'(b);    end
         p = longint'(sa / sbv); e.lo = p[15:0];
         p = longint'(sa % sbv); e.hi = p[15:0];
      end
      return e;
   endfunction

   // Runs one operation; optionally pulses start again mid-operation to check it is ignored.
   task automatic run_op(input string tag, input bit dv, input bit sg, input logic [15:0] a,
                         input logic [15:0] b, input int exp_busy, input bit poke);
      exp_t e;
      int   nb = 0, i = 0;
      bit   seen = 0;
      sb.push_back(model(dv, sg, a, b));
      @(negedge clk);
      start = 1'b1; op_div = dv; op_signed = sg; opa = a; opb = b;
      @(posedge clk); #1;
      start = 1'b0;
      while (!seen && i < 40) begin
         i++;
         if (i > 1) begin @(posedge clk); #1; end
         if (poke && i == 5) begin start = 1'b1; opa = 16'h5555; opb = 16'h0003; end
         if (poke && i == 6) start = 1'b0;
         if (busy) nb++;
         if (done) begin
            seen = 1'b1;
            e = sb.pop_front();
            check({tag, "_lo"}, {16'h0, result_lo}, {16'h0, e.lo});
            check({tag, "_hi"}, {16'h0, result_hi}, {16'h0, e.hi});
            check({tag, "_dz"}, {31'h0, div_zero}, {31'h0, e.dz});
         end
      end
      check({tag, "_done_seen"}, {31'h0, seen}, 32'h1);
      check({tag, "_latency"}, nb, exp_busy);
      @(posedge clk); #1;
      check({tag, "_idle_after"}, {30'h0, busy, done}, 32'h0);
   endtask

   // Starts a MUL and aborts it with reset (use_rst) or en=0 five cycles in.
   task automatic abort_op(input string tag, input bit use_rst, input logic [15:0] klo,
                           input logic [15:0] khi, input logic kdz);
      int nd = 0;
      @(negedge clk);
      start = 1'b1; op_div = 1'b0; op_signed = 1'b0; opa = 16'h7777; opb = 16'h0101;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      if (use_rst) rst_n = 1'b0; else en = 1'b0;
      @(posedge clk); #1;
      check({tag, "_busy_done"}, {30'h0, busy, done}, 32'h0);
      check({tag, "_res"}, {result_hi, result_lo}, {khi, klo});
      check({tag, "_dz"}, {31'h0, div_zero}, {31'h0, kdz});
      rst_n = 1'b1; en = 1'b1;
      repeat (20) begin @(posedge clk); #1; if (done) nd++; end
      check({tag, "_no_done"}, nd, 0);
   endtask

   initial begin
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", {31'h0, busy}, 32'h0);
      check("rst_done", {31'h0, done}, 32'h0);
      check("rst_lo", {16'h0, result_lo}, 32'h0);
      check("rst_hi", {16'h0, result_hi}, 32'h0);
      check("rst_dz", {31'h0, div_zero}, 32'h0);
      @(negedge clk); rst_n = 1'b1;

      run_op("mul_1234x10", 1'b0, 1'b0, 16'h1234, 16'h0010, 17, 1'b1);
      check("mul_1234_const", {result_hi, result_lo}, 32'h0001_2340);
      run_op("mul_ffffxffff", 1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 17, 1'b0);
      check("mul_ffff_const", {result_hi, result_lo}, 32'hFFFE_0001);
      run_op("div_100_7", 1'b1, 1'b0, 16'd100, 16'd7, 17, 1'b0);
      check("div_100_const", {result_hi, result_lo}, 32'h0002_000E);
      run_op("div_zero", 1'b1, 1'b0, 16'h00AB, 16'h0000, 1, 1'b0);
      check("divz_const", {result_hi, result_lo}, 32'h00AB_FFFF);
      run_op("div_big", 1'b1, 1'b0, 16'hFFFF, 16'h0001, 17, 1'b0);
      run_op("div_small", 1'b1, 1'b0, 16'h0003, 16'h8000, 17, 1'b0);

      abort_op("abort_rst", 1'b1, 16'h0, 16'h0, 1'b0);
      run_op("mul_after_rst", 1'b0, 1'b0, 16'h0003, 16'h0005, 17, 1'b0);
      abort_op("abort_en", 1'b0, 16'h000F, 16'h0000, 1'b0);
      run_op("div_after_en", 1'b1, 1'b0, 16'hC350, 16'h00FB, 17, 1'b0);

      run_op("sdiv_fff9_2", 1'b1, 1'b1, 16'hFFF9, 16'h0002, 17, 1'b0);
`ifdef ALU_MULDIV_SIGNED_EN
      check("sdiv_const", {result_hi, result_lo}, 32'hFFFF_FFFD);
`else
      check("sdiv_const", {result_hi, result_lo}, 32'h0001_7FFC);
`endif
      run_op("smul_fffd_5", 1'b0, 1'b1, 16'hFFFD, 16'h0005, 17, 1'b0);
      run_op("sdiv_8000_ffff", 1'b1, 1'b1, 16'h8000, 16'hFFFF, 17, 1'b0);
      run_op("smul_neg_neg", 1'b0, 1'b1, 16'h8000, 16'h8000, 17, 1'b0);
      run_op("sdiv_zero", 1'b1, 1'b1, 16'hFF00, 16'h0000, 1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
